// File: rtl/cache_ctrl_pkg.sv
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared state encoding and address-field helpers for the
//               write-back cache refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_ctrl_pkg;

  localparam int unsigned STATE_WIDTH = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    REFILL     = 2'd2
  } state_e;

  // Address layout is {tag, index, word, 2'b00}; these give field LSB positions.
  function automatic int unsigned tag_lsb(input int unsigned set_w, input int unsigned off_w);
    return set_w + off_w;
  endfunction

  function automatic int unsigned index_lsb(input int unsigned off_w);
    return off_w;
  endfunction

  function automatic int unsigned beat_width(input int unsigned off_w);
    return off_w - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/beat_counter.sv
// ============================================================================
// Module      : beat_counter
// Description : Line beat index with clear/advance; holds at the last beat
//               so it only returns to zero through an explicit clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] count_o,
  output logic             last_o
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_count <= '0;
    end else if (advance_i && !last_o) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count_o = r_count;
  assign last_o  = &r_count;

endmodule

`default_nettype wire

// File: rtl/cache_refill_controller.sv
// ============================================================================
// Module      : cache_refill_controller
// Description : Write-back cache miss controller with req/ready memory beats.
//               Define CACHE_STATS_EN to build saturating hit/miss/wb counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_refill_controller
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned TAG_WIDTH    = 22,
  parameter int unsigned SET_WIDTH    = 4,
  parameter int unsigned OFFSET_WIDTH = 6,
  parameter int unsigned STAT_WIDTH   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    write_en_i,
  input  logic [31:0]             addr_i,
  input  logic                    hit_i,
  input  logic                    dirty_i,
  input  logic [TAG_WIDTH-1:0]    tag_line_i,
  output logic                    stall_o,
  output logic                    line_we_o,
  output logic                    set_valid_o,
  output logic                    set_dirty_o,
  output logic                    strategy_en_o,
  output logic                    offset_sel_o,
  output logic [OFFSET_WIDTH-3:0] offset_line_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [31:0]             mem_addr_o,
  input  logic                    mem_ready_i,
  output logic [1:0]              state_o,
  output logic [STAT_WIDTH-1:0]   hit_cnt_o,
  output logic [STAT_WIDTH-1:0]   miss_cnt_o,
  output logic [STAT_WIDTH-1:0]   wb_cnt_o
);

  localparam int unsigned c_BEAT_WIDTH = beat_width(OFFSET_WIDTH);
  localparam int unsigned c_TAG_LSB    = tag_lsb(SET_WIDTH, OFFSET_WIDTH);
  localparam int unsigned c_INDEX_LSB  = index_lsb(OFFSET_WIDTH);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic [TAG_WIDTH-1:0]    r_victim_tag;
  logic [SET_WIDTH-1:0]    r_index;
  logic [c_BEAT_WIDTH-1:0] w_beat;
  logic                    w_last_beat;
  logic                    w_beat_clear;
  logic                    w_beat_advance;
  logic                    w_miss;
  logic                    w_unused_offset;

  assign w_miss          = (r_state == IDLE) && en_i && !hit_i;
  assign w_unused_offset = ^addr_i[OFFSET_WIDTH-1:0];

  beat_counter #(
    .WIDTH (c_BEAT_WIDTH)
  ) u_beat_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (w_beat_clear),
    .advance_i (w_beat_advance),
    .count_o   (w_beat),
    .last_o    (w_last_beat)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The processor may move on once stalled, so the miss context is captured here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tag        <= '0;
      r_index      <= '0;
      r_victim_tag <= '0;
    end else if (w_miss) begin
      r_tag        <= addr_i[c_TAG_LSB +: TAG_WIDTH];
      r_index      <= addr_i[c_INDEX_LSB +: SET_WIDTH];
      r_victim_tag <= tag_line_i;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    stall_o        = 1'b0;
    line_we_o      = 1'b0;
    set_valid_o    = 1'b0;
    set_dirty_o    = 1'b0;
    strategy_en_o  = 1'b0;
    offset_sel_o   = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    w_beat_clear   = 1'b0;
    w_beat_advance = 1'b0;

    case (r_state)
      IDLE: begin
        if (en_i) begin
          if (hit_i) begin
            line_we_o     = write_en_i;
            set_dirty_o   = write_en_i;
            strategy_en_o = 1'b1;
          end else begin
            stall_o      = 1'b1;
            w_beat_clear = 1'b1;
            w_state_next = dirty_i ? WRITE_BACK : REFILL;
          end
        end
      end
      WRITE_BACK: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {r_victim_tag, r_index, w_beat, 2'b00};
        if (mem_ready_i) begin
          w_beat_advance = 1'b1;
          if (w_last_beat) begin
            w_beat_clear = 1'b1;
            w_state_next = REFILL;
          end
        end
      end
      REFILL: begin
        stall_o      = 1'b1;
        mem_req_o    = 1'b1;
        offset_sel_o = 1'b1;
        mem_addr_o   = {r_tag, r_index, w_beat, 2'b00};
        if (mem_ready_i) begin
          line_we_o      = 1'b1;
          w_beat_advance = 1'b1;
          if (w_last_beat) begin
            set_valid_o   = 1'b1;
            strategy_en_o = 1'b1;
            w_beat_clear  = 1'b1;
            w_state_next  = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign offset_line_o = w_beat;
  assign state_o       = r_state;

`ifdef CACHE_STATS_EN
  logic [STAT_WIDTH-1:0] r_hit_cnt;
  logic [STAT_WIDTH-1:0] r_miss_cnt;
  logic [STAT_WIDTH-1:0] r_wb_cnt;
  logic                  w_hit_evt;
  logic                  w_wb_evt;

  assign w_hit_evt = (r_state == IDLE) && en_i && hit_i;
  assign w_wb_evt  = w_miss && dirty_i;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_hit_evt && !(&r_hit_cnt)) begin
        r_hit_cnt <= r_hit_cnt + STAT_WIDTH'(1);
      end
      if (w_miss && !(&r_miss_cnt)) begin
        r_miss_cnt <= r_miss_cnt + STAT_WIDTH'(1);
      end
      if (w_wb_evt && !(&r_wb_cnt)) begin
        r_wb_cnt <= r_wb_cnt + STAT_WIDTH'(1);
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
  assign wb_cnt_o   = r_wb_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
  assign wb_cnt_o   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_controller.sv
// ============================================================================
// Module      : tb_cache_refill_controller
// Description : Randomized self-checking bench against a line-level cache and
//               memory-beat reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cache_refill_controller;

  localparam int TW = 24;
  localparam int SW = 4;
  localparam int OW = 4;
  localparam int BW = OW - 2;
  localparam int LW = 1 << BW;
  localparam int STAT_WIDE   = 16;
  localparam int STAT_NARROW = 2;

  logic clk = 1'b0;
  logic rst, en, we, hit, dirty, ready;
  logic [31:0] addr;
  logic [TW-1:0] tag_line;

  logic stall, line_we, set_valid, set_dirty, strategy_en, offset_sel, mem_req, mem_we;
  logic [BW-1:0] offset_line;
  logic [31:0] mem_addr;
  logic [1:0] state;
  logic [STAT_WIDE-1:0] hit_cnt, miss_cnt, wb_cnt;

  logic n_unused_stall, n_unused_line_we, n_unused_set_valid, n_unused_set_dirty;
  logic n_unused_strategy_en, n_unused_offset_sel, n_unused_mem_req, n_unused_mem_we;
  logic [BW-1:0] n_unused_offset_line;
  logic [31:0] n_unused_mem_addr;
  logic [1:0] n_unused_state;
  logic [STAT_NARROW-1:0] hit_cnt_n, miss_cnt_n, wb_cnt_n;

  always #5 clk = ~clk;

  cache_refill_controller #(
    .TAG_WIDTH(TW), .SET_WIDTH(SW), .OFFSET_WIDTH(OW), .STAT_WIDTH(STAT_WIDE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .write_en_i(we), .addr_i(addr),
    .hit_i(hit), .dirty_i(dirty), .tag_line_i(tag_line),
    .stall_o(stall), .line_we_o(line_we), .set_valid_o(set_valid), .set_dirty_o(set_dirty),
    .strategy_en_o(strategy_en), .offset_sel_o(offset_sel), .offset_line_o(offset_line),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_ready_i(ready),
    .state_o(state), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt)
  );

  cache_refill_controller #(
    .TAG_WIDTH(TW), .SET_WIDTH(SW), .OFFSET_WIDTH(OW), .STAT_WIDTH(STAT_NARROW)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .write_en_i(we), .addr_i(addr),
    .hit_i(hit), .dirty_i(dirty), .tag_line_i(tag_line),
    .stall_o(n_unused_stall), .line_we_o(n_unused_line_we), .set_valid_o(n_unused_set_valid),
    .set_dirty_o(n_unused_set_dirty), .strategy_en_o(n_unused_strategy_en),
    .offset_sel_o(n_unused_offset_sel), .offset_line_o(n_unused_offset_line),
    .mem_req_o(n_unused_mem_req), .mem_we_o(n_unused_mem_we), .mem_addr_o(n_unused_mem_addr),
    .mem_ready_i(ready), .state_o(n_unused_state),
    .hit_cnt_o(hit_cnt_n), .miss_cnt_o(miss_cnt_n), .wb_cnt_o(wb_cnt_n)
  );

  typedef struct {
    logic [31:0] a;
    bit          wb;
    int          k;
  } beat_t;

  // Reference cache contents (one line per set) and event tallies.
  logic [TW-1:0] m_tag [16];
  bit            m_valid [16];
  bit            m_dirty [16];
  int            m_hits, m_miss, m_wb;
  int            n_tests, n_fail;
  int            mode;
  int            rst_beat;
  bit            aborted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic check_counters(input string tag);
`ifdef CACHE_STATS_EN
    check_eq({tag, "_hit"},    32'(hit_cnt),    32'(sat(m_hits, STAT_WIDE)));
    check_eq({tag, "_miss"},   32'(miss_cnt),   32'(sat(m_miss, STAT_WIDE)));
    check_eq({tag, "_wb"},     32'(wb_cnt),     32'(sat(m_wb, STAT_WIDE)));
    check_eq({tag, "_hit_s"},  32'(hit_cnt_n),  32'(sat(m_hits, STAT_NARROW)));
    check_eq({tag, "_miss_s"}, 32'(miss_cnt_n), 32'(sat(m_miss, STAT_NARROW)));
    check_eq({tag, "_wb_s"},   32'(wb_cnt_n),   32'(sat(m_wb, STAT_NARROW)));
`else
    check_eq({tag, "_hit"},    32'(hit_cnt),    32'd0);
    check_eq({tag, "_miss"},   32'(miss_cnt),   32'd0);
    check_eq({tag, "_wb"},     32'(wb_cnt),     32'd0);
    check_eq({tag, "_hit_s"},  32'(hit_cnt_n),  32'd0);
`endif
  endtask

  task automatic idle_cycle();
    en = 1'b0; we = 1'($urandom); addr = $urandom; hit = 1'($urandom);
    dirty = 1'($urandom); ready = 1'($urandom);
    @(negedge clk);
    check_eq("idle_stall",   32'(stall),       32'd0);
    check_eq("idle_line_we", 32'(line_we),     32'd0);
    check_eq("idle_strat",   32'(strategy_en), 32'd0);
    check_eq("idle_req",     32'(mem_req),     32'd0);
    check_eq("idle_state",   32'(state),       32'd0);
    check_eq("idle_beat",    32'(offset_line), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] make_addr(input int t, input int idx, input int off);
    return (32'(t) << (SW + OW)) | (32'(idx) << OW) | 32'(off);
  endfunction

  task automatic do_access(input bit w, input logic [31:0] a);
    logic [TW-1:0] t;
    int idx, cyc, hold_left;
    bit done;
    beat_t q[$];
    beat_t b;
    t = a[31 -: TW];
    idx = int'(a[OW +: SW]);
    done = 1'b0;
    aborted = 1'b0;
    for (int attempt = 0; attempt < 2 && !done; attempt++) begin
      en = 1'b1; we = w; addr = a; ready = 1'($urandom);
      hit = m_valid[idx] && (m_tag[idx] == t);
      dirty = m_valid[idx] && m_dirty[idx];
      tag_line = m_tag[idx];
      @(negedge clk);
      check_eq("acc_state", 32'(state), 32'd0);
      check_eq("acc_req",   32'(mem_req), 32'd0);
      if (hit) begin
        check_eq("hit_stall",   32'(stall),       32'd0);
        check_eq("hit_line_we", 32'(line_we),     32'(w));
        check_eq("hit_dirty",   32'(set_dirty),   32'(w));
        check_eq("hit_strat",   32'(strategy_en), 32'd1);
        check_eq("hit_osel",    32'(offset_sel),  32'd0);
        m_hits++;
        if (w) m_dirty[idx] = 1'b1;
        done = 1'b1;
        @(posedge clk); #1;
      end else begin
        check_eq("miss_stall",   32'(stall),   32'd1);
        check_eq("miss_line_we", 32'(line_we), 32'd0);
        m_miss++;
        q.delete();
        if (dirty) begin
          m_wb++;
          for (int k = 0; k < LW; k++) q.push_back('{make_addr(int'(m_tag[idx]), idx, k * 4), 1'b1, k});
        end
        for (int k = 0; k < LW; k++) q.push_back('{make_addr(int'(t), idx, k * 4), 1'b0, k});
        @(posedge clk); #1;
        cyc = 0;
        hold_left = 3;
        while (q.size() > 0 && cyc < 200) begin
          b = q[0];
          en = 1'($urandom); we = 1'($urandom); addr = $urandom;
          hit = 1'($urandom); dirty = 1'($urandom);
          case (mode)
            1: ready = 1'b1;
            2: begin
              if (!b.wb && b.k == 1 && hold_left > 0) begin
                ready = 1'b0;
                hold_left--;
              end else begin
                ready = 1'b1;
              end
            end
            default: ready = ($urandom_range(0, 2) != 0);
          endcase
          if (rst_beat >= 0 && !b.wb && b.k == rst_beat) rst = 1'b1;
          @(negedge clk);
          check_eq("beat_req",   32'(mem_req),     32'd1);
          check_eq("beat_stall", 32'(stall),       32'd1);
          check_eq("beat_we",    32'(mem_we),      32'(b.wb));
          check_eq("beat_addr",  mem_addr,         b.a);
          check_eq("beat_idx",   32'(offset_line), 32'(b.k));
          check_eq("beat_state", 32'(state),       b.wb ? 32'd1 : 32'd2);
          check_eq("beat_osel",  32'(offset_sel),  32'(!b.wb));
          if (!b.wb) begin
            check_eq("refill_line_we", 32'(line_we),     32'(ready));
            check_eq("refill_dirty",   32'(set_dirty),   32'd0);
            check_eq("refill_valid",   32'(set_valid),   32'(ready && q.size() == 1));
            check_eq("refill_strat",   32'(strategy_en), 32'(ready && q.size() == 1));
          end
          if (ready) void'(q.pop_front());
          cyc++;
          @(posedge clk); #1;
          if (rst) begin
            rst = 1'b0;
            aborted = 1'b1;
            break;
          end
        end
        if (aborted) begin
          m_hits = 0; m_miss = 0; m_wb = 0;
          done = 1'b1;
        end else begin
          check_eq("beat_budget", 32'(q.size()), 32'd0);
          m_tag[idx] = t; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; m_hits = 0; m_miss = 0; m_wb = 0;
    mode = 1; rst_beat = -1; aborted = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_tag[i] = '0; m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
    end
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; hit = 1'b0; dirty = 1'b0;
    ready = 1'b0; tag_line = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_state", 32'(state),       32'd0);
    check_eq("rst_req",   32'(mem_req),     32'd0);
    check_eq("rst_stall", 32'(stall),       32'd0);
    check_eq("rst_beat",  32'(offset_line), 32'd0);
    check_counters("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Clean read miss with always-ready memory, then hits and one dirty miss on set 7.
    do_access(1'b0, make_addr(1, 7, 0));
    do_access(1'b1, make_addr(1, 7, 4));
    for (int i = 0; i < 4; i++) do_access(1'b0, make_addr(1, 7, 4 * i));
    do_access(1'b0, make_addr(2, 7, 8));
    idle_cycle();
    check_counters("stats");

    // Store miss into a clean set, then a store that evicts the dirty 0x2A line.
    do_access(1'b1, make_addr(32'h2A, 5, 0));
    do_access(1'b1, make_addr(3, 5, 12));

    // Memory withholds ready for three cycles on refill beat 1.
    mode = 2;
    do_access(1'b0, make_addr(1, 6, 0));
    mode = 1;

    // Reset lands while refill beat 2 is outstanding.
    rst_beat = 2;
    do_access(1'b0, make_addr(1, 8, 0));
    rst_beat = -1;
    en = 1'b0; hit = 1'b0; ready = 1'b1;
    @(negedge clk);
    check_eq("abort_flag",  32'(aborted),     32'd1);
    check_eq("abort_state", 32'(state),       32'd0);
    check_eq("abort_req",   32'(mem_req),     32'd0);
    check_eq("abort_beat",  32'(offset_line), 32'd0);
    check_counters("abort");
    @(posedge clk); #1;

    mode = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      do_access(1'($urandom), make_addr($urandom_range(0, 2), $urandom_range(0, 3),
                                        $urandom_range(0, 15)));
    end
    idle_cycle();
    check_counters("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
